// File: rtl/qpsk_tx_framer_pkg.sv
// rtl/qpsk_tx_framer_pkg.sv - shared frame constants, FSM states and checksum helper for the QPSK framer
package qpsk_tx_framer_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hCC;
  localparam int         FRAME_BITS     = 56;
  localparam int         FRAME_SYMS     = 28;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_SEND     = 2'd2
  } tx_state_e;

  // Modulo-256 sum of the five payload bytes, matching the receive-side frame check.
  function automatic logic [7:0] csum8(input logic [39:0] d);
    return d[39:32] + d[31:24] + d[23:16] + d[15:8] + d[7:0];
  endfunction

endpackage

// File: rtl/qpsk_tx_framer_sym_tick_gen.sv
// rtl/qpsk_tx_framer_sym_tick_gen.sv - free-running symbol-period counter producing one tick per symbol
module qpsk_tx_framer_sym_tick_gen #(
  parameter int SYM_DIV = 10000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int            CW   = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SYM_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/qpsk_tx_framer.sv
// rtl/qpsk_tx_framer.sv - QPSK transmit framer: payload buffer, preamble, header/checksum framing, I/Q mapping
module qpsk_tx_framer
  import qpsk_tx_framer_pkg::*;
#(
  parameter logic [7:0] HEADER        = HEADER_DEFAULT,
  parameter int         SYM_DIV       = 10000,
  parameter int         PREAMBLE_SYMS = 16,
  parameter logic [1:0] IDLE_SYM      = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        sym_i,
  output logic        sym_q,
  output logic        sym_strobe,
  output logic        busy,
  output logic        frame_done
);

  localparam int            PW       = $clog2(PREAMBLE_SYMS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_SYMS);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [4:0]    LAST_SYM = 5'(FRAME_SYMS);

  logic tick;

  qpsk_tx_framer_sym_tick_gen #(
    .SYM_DIV(SYM_DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_i (rst),
    .tick_o(tick)
  );

  tx_state_e             state_q, state_d;
  logic [47:0]           buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  din_ready_q;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] frame_next;
  logic [PW-1:0]         pre_cnt_q, pre_cnt_d;
  logic [4:0]            sym_cnt_q, sym_cnt_d;
  logic [1:0]            out_sym_q, out_sym_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  strobe_q;
  logic                  accept;
  logic                  drain;

  assign accept     = din_valid & din_ready_q;
  assign frame_next = {HEADER, buf_q};

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pre_cnt_d = pre_cnt_q;
    sym_cnt_d = sym_cnt_q;
    out_sym_d = out_sym_q;
    busy_d    = busy_q;
    done_d    = done_q;
    drain     = 1'b0;

    if (tick) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          out_sym_d = IDLE_SYM;
          busy_d    = 1'b0;
          if (buf_full_q) begin
            drain     = 1'b1;
            shreg_d   = frame_next;
            out_sym_d = 2'b11;
            pre_cnt_d = PRE_ONE;
            busy_d    = 1'b1;
            state_d   = ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          if (pre_cnt_q == PRE_LAST) begin
            out_sym_d = shreg_q[FRAME_BITS-1 -: 2];
            shreg_d   = {shreg_q[FRAME_BITS-3:0], 2'b00};
            sym_cnt_d = 5'd1;
            state_d   = ST_SEND;
          end else begin
            out_sym_d = pre_cnt_q[0] ? 2'b00 : 2'b11;
            pre_cnt_d = pre_cnt_q + 1'b1;
          end
        end
        ST_SEND: begin
          if (sym_cnt_q == LAST_SYM) begin
            done_d = 1'b1;
            // A waiting frame starts on the very tick the previous one ends: no preamble, no gap.
            if (buf_full_q) begin
              drain     = 1'b1;
              out_sym_d = frame_next[FRAME_BITS-1 -: 2];
              shreg_d   = {frame_next[FRAME_BITS-3:0], 2'b00};
              sym_cnt_d = 5'd1;
            end else begin
              out_sym_d = IDLE_SYM;
              busy_d    = 1'b0;
              state_d   = ST_IDLE;
            end
          end else begin
            out_sym_d = shreg_q[FRAME_BITS-1 -: 2];
            shreg_d   = {shreg_q[FRAME_BITS-3:0], 2'b00};
            sym_cnt_d = sym_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    buf_full_d = (buf_full_q & ~drain) | accept;
    buf_d      = accept ? {din, csum8(din)} : buf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      din_ready_q <= 1'b0;
      shreg_q     <= '0;
      pre_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      out_sym_q   <= IDLE_SYM;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      din_ready_q <= ~buf_full_d;
      shreg_q     <= shreg_d;
      pre_cnt_q   <= pre_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      out_sym_q   <= out_sym_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      strobe_q    <= tick;
    end
  end

  assign din_ready  = din_ready_q;
  assign sym_i      = out_sym_q[1];
  assign sym_q      = out_sym_q[0];
  assign sym_strobe = strobe_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
